multi_timer: RTL and testbench

Multi-channel programmable interval timer with a shared prescaler and per-channel one-shot or periodic mode. Each channel latches its own period at start and emits a single-cycle `update_flag` pulse at every expiry. It drives sampling, update and scheduling strobes in the processing datapath and replaces the single fixed-period one-shot timer.

---
 rtl/multi_timer_if.sv | 27 ++
 rtl/multi_timer.sv | 100 ++++++++++
 tb/tb_multi_timer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_timer_if.sv
// Control/status bundle for multi_timer: the host drives the timer controls,
// the timer returns per-channel expiry pulses, run status and tick counts.
interface multi_timer_if #(
    parameter int NCH   = 4,
    parameter int CW    = 32,
    parameter int PSC_W = 16
);
    logic                 en;
    logic [PSC_W-1:0]     prescale;
    logic [NCH-1:0]       start;
    logic [NCH-1:0]       stop;
    logic [NCH-1:0]       periodic;
    logic [NCH*CW-1:0]    period;
    logic [NCH-1:0]       update_flag;
    logic [NCH-1:0]       busy;
    logic [NCH*CW-1:0]    count;

    modport master (
        output en, prescale, start, stop, periodic, period,
        input  update_flag, busy, count
    );

    modport slave (
        input  en, prescale, start, stop, periodic, period,
        output update_flag, busy, count
    );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel interval timer: one shared prescaler tick feeds NCH independent
// one-shot/periodic channels, each pulsing update_flag for one cycle on expiry.
module multi_timer #(
    parameter int NCH   = 4,
    parameter int CW    = 32,
    parameter int PSC_W = 16
) (
    input  logic           clk,
    input  logic           rstn,
    multi_timer_if.slave   bus
);

    typedef enum logic {IDLE, RUN} state_e;

    logic [PSC_W-1:0] psc_q, psc_d;
    logic             tick;

    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [CW-1:0]    cnt_q   [NCH];
    logic [CW-1:0]    cnt_d   [NCH];
    logic [CW-1:0]    per_q   [NCH];
    logic [CW-1:0]    per_d   [NCH];
    logic [NCH-1:0]   mode_q, mode_d;
    logic [NCH-1:0]   flag_q, flag_d;

    // A prescale lowered below the running phase snaps psc back to 0 without a tick.
    always_comb begin
        tick  = bus.en && (psc_q == bus.prescale);
        psc_d = psc_q;
        if (bus.en) begin
            if (tick || (psc_q > bus.prescale))
                psc_d = '0;
            else
                psc_d = psc_q + PSC_W'(1);
        end
    end

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            per_d[i]   = per_q[i];
            mode_d[i]  = mode_q[i];
            flag_d[i]  = 1'b0;
            if (bus.en) begin
                if (bus.stop[i]) begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end else if (bus.start[i] && (bus.period[i*CW +: CW] != '0)) begin
                    // Restart wins over a coincident expiry, so that flag is dropped.
                    state_d[i] = RUN;
                    cnt_d[i]   = '0;
                    per_d[i]   = bus.period[i*CW +: CW];
                    mode_d[i]  = bus.periodic[i];
                end else if ((state_q[i] == RUN) && tick) begin
                    if (cnt_q[i] == per_q[i] - CW'(1)) begin
                        flag_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                        state_d[i] = mode_q[i] ? RUN : IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all channels update from the same pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            psc_q  <= '0;
            mode_q <= '0;
            flag_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                per_q[i]   <= '0;
            end
        end else begin
            psc_q  <= psc_d;
            mode_q <= mode_d;
            flag_q <= flag_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                per_q[i]   <= per_d[i];
            end
        end
    end

    assign bus.update_flag = flag_q;

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign bus.busy[g]              = (state_q[g] == RUN);
        assign bus.count[g*CW +: CW]    = cnt_q[g];
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (NCH=4, CW=8): one task per scenario, each with
// hand-computed expected flags, busy bits and counts.
module tb_multi_timer;

    localparam int NCH   = 4;
    localparam int CW    = 8;
    localparam int PSC_W = 16;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    multi_timer_if #(.NCH(NCH), .CW(CW), .PSC_W(PSC_W)) bus ();

    multi_timer #(.NCH(NCH), .CW(CW), .PSC_W(PSC_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_period(input int ch, input int p);
        bus.period[ch*CW +: CW] = CW'(p);
    endtask

    task automatic test_reset();
        rstn         = 1'b0;
        bus.en       = 1'b0;
        bus.prescale = '0;
        bus.start    = '0;
        bus.stop     = '0;
        bus.periodic = '0;
        bus.period   = '0;
        #3;
        checks++;
        if (bus.update_flag !== 4'h0) begin
            errors++; $display("FAIL reset_flag: got %h expected 0", bus.update_flag);
        end
        checks++;
        if (bus.busy !== 4'h0) begin
            errors++; $display("FAIL reset_busy: got %h expected 0", bus.busy);
        end
        checks++;
        if (bus.count !== 32'h0) begin
            errors++; $display("FAIL reset_count: got %h expected 0", bus.count);
        end
        step();
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (bus.busy !== 4'h0 || bus.count !== 32'h0) begin
            errors++; $display("FAIL reset_release: got busy %h count %h expected 0/0", bus.busy, bus.count);
        end
    endtask

    task automatic test_oneshot();
        logic exp_f, exp_b;
        int   exp_c;
        bus.en       = 1'b1;
        bus.prescale = '0;
        set_period(0, 5);
        bus.periodic[0] = 1'b0;
        bus.start[0]    = 1'b1;
        step();
        bus.start[0]    = 1'b0;
        checks++;
        if (bus.busy[0] !== 1'b1 || bus.count[0 +: CW] !== 8'd0) begin
            errors++; $display("FAIL oneshot_start: got busy %b count %0d expected 1/0", bus.busy[0], bus.count[0 +: CW]);
        end
        for (int k = 1; k <= 55; k++) begin
            step();
            exp_f = (k == 5);
            exp_b = (k < 5);
            exp_c = (k < 5) ? k : 0;
            checks++;
            if (bus.update_flag !== {3'b000, exp_f}) begin
                errors++; $display("FAIL oneshot_flag k=%0d: got %b expected %b", k, bus.update_flag, {3'b000, exp_f});
            end
            checks++;
            if (bus.busy[0] !== exp_b || bus.count[0 +: CW] !== CW'(exp_c)) begin
                errors++; $display("FAIL oneshot_state k=%0d: got busy %b count %0d expected %b/%0d", k, bus.busy[0], bus.count[0 +: CW], exp_b, exp_c);
            end
        end
    endtask

    task automatic test_periodic_en();
        int   lat;
        bit   found;
        logic exp_f;
        int   exp_c;
        bus.prescale = 16'd2;
        set_period(1, 3);
        bus.periodic[1] = 1'b1;
        bus.start[1]    = 1'b1;
        step();
        bus.start[1]    = 1'b0;
        lat   = 0;
        found = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.update_flag[1] === 1'b1) begin
                lat   = k;
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || lat < 7 || lat > 9) begin
            errors++; $display("FAIL periodic_first_latency: got %0d (found %b) expected 7..9", lat, found);
            bus.stop[1] = 1'b1; step(); bus.stop[1] = 1'b0;
            return;
        end
        for (int e = 1; e <= 94; e++) begin
            if (e == 50) begin
                bus.en = 1'b0;
                for (int f = 0; f < 4; f++) begin
                    step();
                    checks++;
                    if (bus.update_flag !== 4'h0 || bus.count[CW +: CW] !== 8'd1) begin
                        errors++; $display("FAIL periodic_freeze f=%0d: got flag %b count %0d expected 0000/1", f, bus.update_flag, bus.count[CW +: CW]);
                    end
                end
                bus.en = 1'b1;
            end
            step();
            exp_f = ((e % 9) == 0);
            exp_c = (e % 9) / 3;
            checks++;
            if (bus.update_flag !== {2'b00, exp_f, 1'b0}) begin
                errors++; $display("FAIL periodic_flag e=%0d: got %b expected %b", e, bus.update_flag, {2'b00, exp_f, 1'b0});
            end
            checks++;
            if (bus.count[CW +: CW] !== CW'(exp_c)) begin
                errors++; $display("FAIL periodic_count e=%0d: got %0d expected %0d", e, bus.count[CW +: CW], exp_c);
            end
        end
        bus.stop[1] = 1'b1;
        step();
        bus.stop[1] = 1'b0;
        checks++;
        if (bus.busy[1] !== 1'b0 || bus.count[CW +: CW] !== 8'd0) begin
            errors++; $display("FAIL periodic_stop: got busy %b count %0d expected 0/0", bus.busy[1], bus.count[CW +: CW]);
        end
    endtask

    task automatic test_restart();
        logic exp_f;
        bus.prescale = '0;
        set_period(2, 10);
        bus.periodic[2] = 1'b0;
        bus.start[2]    = 1'b1;
        step();
        bus.start[2]    = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (bus.count[2*CW +: CW] !== CW'(k)) begin
                errors++; $display("FAIL restart_count k=%0d: got %0d expected %0d", k, bus.count[2*CW +: CW], k);
            end
        end
        set_period(2, 4);
        bus.start[2] = 1'b1;
        step();
        bus.start[2] = 1'b0;
        checks++;
        if (bus.count[2*CW +: CW] !== 8'd0 || bus.busy[2] !== 1'b1 || bus.update_flag !== 4'h0) begin
            errors++; $display("FAIL restart_latch: got count %0d busy %b flag %b expected 0/1/0000", bus.count[2*CW +: CW], bus.busy[2], bus.update_flag);
        end
        for (int k = 9; k <= 20; k++) begin
            step();
            exp_f = (k == 12);
            checks++;
            if (bus.update_flag !== {1'b0, exp_f, 2'b00} || bus.busy[2] !== (k < 12)) begin
                errors++; $display("FAIL restart_flag k=%0d: got flag %b busy %b expected %b/%b", k, bus.update_flag, bus.busy[2], {1'b0, exp_f, 2'b00}, (k < 12));
            end
        end
        set_period(2, 10);
        bus.start[2] = 1'b1;
        step();
        bus.start[2] = 1'b0;
        step();
        step();
        set_period(2, 4);
        bus.start[2] = 1'b1;
        bus.stop[2]  = 1'b1;
        step();
        bus.start[2] = 1'b0;
        bus.stop[2]  = 1'b0;
        checks++;
        if (bus.busy[2] !== 1'b0 || bus.count[2*CW +: CW] !== 8'd0) begin
            errors++; $display("FAIL start_stop: got busy %b count %0d expected 0/0", bus.busy[2], bus.count[2*CW +: CW]);
        end
        for (int k = 0; k < 15; k++) begin
            step();
            checks++;
            if (bus.update_flag !== 4'h0) begin
                errors++; $display("FAIL start_stop_flag k=%0d: got %b expected 0000", k, bus.update_flag);
            end
        end
    endtask

    task automatic test_coincide();
        bus.prescale = '0;
        set_period(3, 3);
        bus.periodic[3] = 1'b1;
        bus.start[3]    = 1'b1;
        step();
        bus.start[3]    = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (bus.update_flag[3] !== (k == 3)) begin
                errors++; $display("FAIL coincide_pre k=%0d: got %b expected %b", k, bus.update_flag[3], (k == 3));
            end
        end
        bus.start[3] = 1'b1;
        step();
        bus.start[3] = 1'b0;
        checks++;
        if (bus.update_flag[3] !== 1'b0 || bus.count[3*CW +: CW] !== 8'd0 || bus.busy[3] !== 1'b1) begin
            errors++; $display("FAIL coincide_edge: got flag %b count %0d busy %b expected 0/0/1", bus.update_flag[3], bus.count[3*CW +: CW], bus.busy[3]);
        end
        for (int k = 7; k <= 9; k++) begin
            step();
            checks++;
            if (bus.update_flag[3] !== (k == 9)) begin
                errors++; $display("FAIL coincide_post k=%0d: got %b expected %b", k, bus.update_flag[3], (k == 9));
            end
        end
        set_period(3, 0);
        bus.start[3] = 1'b1;
        step();
        bus.start[3] = 1'b0;
        checks++;
        if (bus.busy[3] !== 1'b1 || bus.count[3*CW +: CW] !== 8'd1) begin
            errors++; $display("FAIL zero_period_run: got busy %b count %0d expected 1/1", bus.busy[3], bus.count[3*CW +: CW]);
        end
        step();
        step();
        checks++;
        if (bus.update_flag !== 4'b1000) begin
            errors++; $display("FAIL zero_period_keep: got %b expected 1000", bus.update_flag);
        end
        bus.stop[3] = 1'b1;
        step();
        bus.stop[3] = 1'b0;
        bus.start[3] = 1'b1;
        step();
        bus.start[3] = 1'b0;
        checks++;
        if (bus.busy[3] !== 1'b0) begin
            errors++; $display("FAIL zero_period_idle: got busy %b expected 0", bus.busy[3]);
        end
    endtask

    task automatic test_all_channels();
        logic [3:0] exp;
        bus.prescale = '0;
        set_period(0, 1);
        set_period(1, 2);
        set_period(2, 7);
        set_period(3, 255);
        bus.periodic = 4'hF;
        bus.start    = 4'hF;
        step();
        bus.start    = 4'h0;
        for (int k = 1; k <= 520; k++) begin
            step();
            exp = {((k % 255) == 0), ((k % 7) == 0), ((k % 2) == 0), 1'b1};
            checks++;
            if (bus.update_flag !== exp) begin
                errors++; $display("FAIL all_flags k=%0d: got %b expected %b", k, bus.update_flag, exp);
            end
            checks++;
            if (bus.count[3*CW +: CW] !== CW'(k % 255) || bus.busy !== 4'hF) begin
                errors++; $display("FAIL all_state k=%0d: got count3 %0d busy %b expected %0d/1111", k, bus.count[3*CW +: CW], bus.busy, k % 255);
            end
        end
    endtask

    task automatic test_reset_mid();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.update_flag !== 4'h0 || bus.busy !== 4'h0 || bus.count !== 32'h0) begin
            errors++; $display("FAIL async_reset: got flag %b busy %b count %h expected 0", bus.update_flag, bus.busy, bus.count);
        end
        step();
        step();
        checks++;
        if (bus.update_flag !== 4'h0 || bus.busy !== 4'h0 || bus.count !== 32'h0) begin
            errors++; $display("FAIL reset_hold: got flag %b busy %b count %h expected 0", bus.update_flag, bus.busy, bus.count);
        end
        rstn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (bus.update_flag !== 4'h0 || bus.busy !== 4'h0) begin
                errors++; $display("FAIL post_reset k=%0d: got flag %b busy %b expected 0/0", k, bus.update_flag, bus.busy);
            end
        end
        bus.periodic = 4'h0;
        set_period(0, 2);
        bus.start[0] = 1'b1;
        step();
        bus.start[0] = 1'b0;
        step();
        step();
        checks++;
        if (bus.update_flag !== 4'b0001 || bus.busy !== 4'h0) begin
            errors++; $display("FAIL post_reset_start: got flag %b busy %b expected 0001/0000", bus.update_flag, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic_en();
        test_restart();
        test_coincide();
        test_all_channels();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
